vid_timing_gen: RTL and testbench
=================================

# vid_timing_gen

Video timing and test-pattern source that drives the TMDS/DVI encoder stage directly. It generates HSync, VSync, data-enable and 24-bit RGB pixel data for a parameterised raster (default 640x480@60, 25.175 MHz pixel clock). The RGB data comes from a built-in pattern generator. Every output is registered in the pixel clock domain, so the encoder sees glitch-free, cycle-aligned timing.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- PixelClk  in  1  pixel clock (1X); the only clock
- aRst  in  1  asynchronous reset, active-high
- en_i  in  1  raster enable; low holds the generator idle
- pattern_sel_i  in  2  pattern select: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
- solid_rgb_i  in  24  colour for pattern 3, {R,G,B}
- vid_pVSync  out  1  VSync, high valid
- vid_pHSync  out  1  HSync, high valid
- vid_pVDE  out  1  data enable, high during active pixels
- vid_pData  out  24  [23:16]R, [15:8]G, [7:0]B; zero when DE is low
- x_o  out  12  active pixel column (valid with DE)
- y_o  out  12  active line (valid with DE)
- frame_start_o  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters are 12-bit: h_cnt runs 0..H_TOTAL-1, v_cnt runs 0..V_TOTAL-1.
  - h_cnt wraps to 0 after H_TOTAL-1. v_cnt increments on that wrap.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HSync is high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751.
- VSync is high for every cycle of lines v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 490..491. It is line-aligned and changes at h_cnt=0.
- Pattern register:
  - Loaded from pattern_sel_i only when the counters are at (0,0).
  - Also loaded when idle (en_i low), so a changed selection takes effect at the next frame start and never mid-frame.
  - solid_rgb_i is sampled continuously.
- Patterns (x = h_cnt, y = v_cnt):
  - 0, colour bars: 8 bars, each H_ACTIVE/8 wide (80 px), bar index = x / (H_ACTIVE/8). Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. For a non-integral bar width the index saturates at 7.
  - 1, grey ramp: R=G=B=x[9:2].
  - 2, checkerboard: FFFFFF when x[5]^y[5]=0, else 000000.
  - 3, solid: solid_rgb_i.
- en_i low:
  - Counters are synchronously cleared to (0,0).
  - The next output register cycle drives all outputs to 0.
  - When en_i rises, counting starts at (0,0), so the first frame begins immediately with an active pixel.
- en_i falling mid-frame or mid-line aborts the frame with no completion. Outputs are zero one cycle later.

## Timing
- Reset value of every output is 0, including x_o, y_o and frame_start_o. The counters reset to (0,0).
- Latency is 1 cycle: counter state (h,v) in cycle n appears on all outputs in cycle n+1. Sync, DE, data, x/y and frame_start are mutually aligned.
- After aRst deasserts with en_i high, the first PixelClk edge loads the outputs for pixel (0,0): DE=1 and frame_start_o=1.
- Frame period is H_TOTAL*V_TOTAL = 420000 cycles. frame_start_o fires exactly once per period.
- x_o and y_o hold the counter values only while DE=1 and are 0 otherwise.
- Reset asserted mid-frame clears everything asynchronously. After release, the generator restarts at (0,0) with no partial line.

## Test plan
- Reset/first pixel: hold aRst with en_i=1, then release. Outputs are 0 during reset. On the first edge after release, DE=1, frame_start_o=1 and x_o=y_o=0.
- Line timing: take t0 as the first DE cycle.
  - DE is high for t0..t0+639.
  - HSync is high for t0+656..t0+751.
  - The next DE rises at t0+800 with y_o=1.
- Frame timing:
  - VSync is high from t0+392000 to t0+393599 (lines 490..491).
  - Lines 480..524 have no DE.
  - frame_start_o repeats at t0+420000.
- Colour bars (sel=0), line 0:
  - x=0 gives FFFFFF, x=80 gives FFFF00, x=639 gives 000000.
  - vid_pData is 0 during blanking.
- Pattern switch: sel changes 0 to 3 with solid_rgb_i=123456 at line 100. The rest of the frame stays colour bars. From the next frame_start onward, every active pixel is 123456.
- Enable abort: en_i drops at h=300 on line 5. One cycle later all outputs are 0. When en_i is re-raised, the next output cycle has frame_start_o=1, x_o=0 and y_o=0.

Source files
------------

// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vid_timing_gen
// Brief    : Raster timing (HSync/VSync/DE) and built-in RGB test-pattern
//            source for a DVI/TMDS encoder. All outputs are registered in
//            the pixel clock domain with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module vid_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        PixelClk,
    input  logic        aRst,
    input  logic        en_i,
    input  logic [1:0]  pattern_sel_i,
    input  logic [23:0] solid_rgb_i,
    output logic        vid_pVSync,
    output logic        vid_pHSync,
    output logic        vid_pVDE,
    output logic [23:0] vid_pData,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        frame_start_o
);

    // Raster geometry expressed at counter width.
    localparam logic [11:0] c_H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] c_H_TOTAL    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] c_V_TOTAL    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
    // Bar width is clamped to 1 so tiny rasters never divide by zero.
    localparam int          c_BAR_W_INT  = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
    localparam logic [11:0] c_BAR_W      = 12'(c_BAR_W_INT);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [1:0]  r_pattern;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_at_origin;
    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;
    logic [1:0]  w_pattern;
    logic [11:0] w_bar_div;
    logic [2:0]  w_bar_idx;
    logic [23:0] w_rgb;

    assign w_h_last    = (r_h_cnt == c_H_TOTAL - 12'd1);
    assign w_v_last    = (r_v_cnt == c_V_TOTAL - 12'd1);
    assign w_at_origin = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_active    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hsync     = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    // VSync depends only on the line counter, so it is line-aligned.
    assign w_vsync     = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // At the origin the live selection is used directly, so the very first
    // pixel of a frame already shows the newly selected pattern.
    assign w_pattern   = w_at_origin ? pattern_sel_i : r_pattern;

    assign w_bar_div   = r_h_cnt / c_BAR_W;
    assign w_bar_idx   = (w_bar_div > 12'd7) ? 3'd7 : w_bar_div[2:0];

    // Horizontal/vertical raster counters; cleared while the raster is idle.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (!en_i) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Pattern selection is captured only at frame start or while idle, so a
    // change never tears a frame in progress.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            r_pattern <= 2'd0;
        end else if (!en_i || w_at_origin) begin
            r_pattern <= pattern_sel_i;
        end
    end

    // Test-pattern colour for the current counter position.
    always_comb begin
        w_rgb = 24'h000000;
        case (w_pattern)
            2'd0: begin
                case (w_bar_idx)
                    3'd0: w_rgb = 24'hFFFFFF;
                    3'd1: w_rgb = 24'hFFFF00;
                    3'd2: w_rgb = 24'h00FFFF;
                    3'd3: w_rgb = 24'h00FF00;
                    3'd4: w_rgb = 24'hFF00FF;
                    3'd5: w_rgb = 24'hFF0000;
                    3'd6: w_rgb = 24'h0000FF;
                    3'd7: w_rgb = 24'h000000;
                endcase
            end
            2'd1:    w_rgb = {3{r_h_cnt[9:2]}};
            2'd2:    w_rgb = (r_h_cnt[5] ^ r_v_cnt[5]) ? 24'h000000 : 24'hFFFFFF;
            default: w_rgb = solid_rgb_i;
        endcase
    end

    // Output register stage: one cycle behind the counters, all aligned.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            vid_pVSync    <= 1'b0;
            vid_pHSync    <= 1'b0;
            vid_pVDE      <= 1'b0;
            vid_pData     <= 24'h000000;
            x_o           <= 12'd0;
            y_o           <= 12'd0;
            frame_start_o <= 1'b0;
        end else if (!en_i) begin
            vid_pVSync    <= 1'b0;
            vid_pHSync    <= 1'b0;
            vid_pVDE      <= 1'b0;
            vid_pData     <= 24'h000000;
            x_o           <= 12'd0;
            y_o           <= 12'd0;
            frame_start_o <= 1'b0;
        end else begin
            vid_pVSync    <= w_vsync;
            vid_pHSync    <= w_hsync;
            vid_pVDE      <= w_active;
            vid_pData     <= w_active ? w_rgb : 24'h000000;
            x_o           <= w_active ? r_h_cnt : 12'd0;
            y_o           <= w_active ? r_v_cnt : 12'd0;
            frame_start_o <= w_at_origin;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vid_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vid_timing_gen
// Brief    : Directed self-checking bench for vid_timing_gen. Uses the full
//            640-pixel line with a shortened frame (8 active lines) so whole
//            frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vid_timing_gen;

    localparam int HA = 640;
    localparam int HT = 800;
    localparam int VA = 8;
    localparam int VT = 15;     // 8 + 2 + 2 + 3
    localparam int FT = HT * VT; // 12000 cycles per frame

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_en;
    logic [1:0]  r_sel;
    logic [23:0] r_solid;

    logic        w_vs;
    logic        w_hs;
    logic        w_de;
    logic [23:0] w_data;
    logic [11:0] w_x;
    logic [11:0] w_y;
    logic        w_fs;

    int r_checks = 0;
    int r_fails  = 0;
    int r_e_de   = 0;
    int r_e_hs   = 0;
    int r_e_vs   = 0;
    int r_e_fs   = 0;
    int r_e_xy   = 0;
    int r_e_data = 0;

    vid_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(8),   .V_FP(2),  .V_SYNC(2),  .V_BP(3)
    ) u_dut (
        .PixelClk      (r_clk),
        .aRst          (r_rst),
        .en_i          (r_en),
        .pattern_sel_i (r_sel),
        .solid_rgb_i   (r_solid),
        .vid_pVSync    (w_vs),
        .vid_pHSync    (w_hs),
        .vid_pVDE      (w_de),
        .vid_pData     (w_data),
        .x_o           (w_x),
        .y_o           (w_y),
        .frame_start_o (w_fs)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    function automatic logic [23:0] exp_rgb(input logic [1:0] pat, input int x, input int y);
        logic [23:0] c;
        case (pat)
            2'd0: begin
                case (x / 80)
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd1:    c = {3{x[9:2]}};
            2'd2:    c = (x[5] ^ y[5]) ? 24'h000000 : 24'hFFFFFF;
            default: c = r_solid;
        endcase
        return c;
    endfunction

    // Compare outputs against the expected raster position n (cycles since
    // the first pixel of the current run); mismatches are tallied per signal.
    task automatic tally(input int n, input logic [1:0] pat);
        int   h;
        int   v;
        logic de;
        h  = n % HT;
        v  = (n / HT) % VT;
        de = (h < HA) && (v < VA);
        if (w_de !== de) r_e_de++;
        if (w_hs !== ((h >= 656) && (h < 752))) r_e_hs++;
        if (w_vs !== ((v >= 10) && (v < 12))) r_e_vs++;
        if (w_fs !== ((h == 0) && (v == 0))) r_e_fs++;
        if ((w_x !== (de ? 12'(h) : 12'd0)) || (w_y !== (de ? 12'(v) : 12'd0))) r_e_xy++;
        if (w_data !== (de ? exp_rgb(pat, h, v) : 24'h000000)) r_e_data++;
    endtask

    initial begin
        r_rst   = 1'b1;
        r_en    = 1'b1;
        r_sel   = 2'd0;
        r_solid = 24'h000000;
        repeat (3) @(posedge r_clk);
        #1;
        check_eq("rst_de",   w_de, 0);
        check_eq("rst_fs",   w_fs, 0);
        check_eq("rst_sync", {w_hs, w_vs}, 0);
        check_eq("rst_xy",   {w_x, w_y}, 0);
        check_eq("rst_data", w_data, 0);
        r_rst = 1'b0;

        // First edge after release shows pixel (0,0).
        step();
        check_eq("first_de",   w_de, 1);
        check_eq("first_fs",   w_fs, 1);
        check_eq("first_xy",   {w_x, w_y}, 0);
        check_eq("first_data", w_data, 24'hFFFFFF);
        tally(0, 2'd0);

        // Two frames of colour bars; solid selected mid-frame on line 4 of
        // frame 2 only takes effect at frame 3.
        for (int n = 1; n <= 28299; n++) begin
            step();
            tally(n, (n < 2 * FT) ? 2'd0 : 2'd3);
            if (n == 80)  check_eq("bar_x80",  w_data, 24'hFFFF00);
            if (n == 639) check_eq("bar_x639", w_data, 24'h000000);
            if (n == 640) check_eq("de_fall",  w_de, 0);
            if (n == 700) check_eq("blank_data", w_data, 24'h000000);
            if (n == 656) check_eq("hs_rise", w_hs, 1);
            if (n == 752) check_eq("hs_fall", w_hs, 0);
            if (n == 800) check_eq("line1_de_y", {w_de, w_y}, {1'b1, 12'd1});
            if (n == 8000) check_eq("vs_rise", w_vs, 1);
            if (n == 9600) check_eq("vs_fall", w_vs, 0);
            if (n == FT) check_eq("frame2_fs", w_fs, 1);
            if (n == FT + 4 * HT) begin
                r_sel   = 2'd3;
                r_solid = 24'h123456;
            end
            if (n == FT + 5 * HT) check_eq("switch_hold_bars", w_data, 24'hFFFFFF);
            if (n == 2 * FT) check_eq("solid_first", w_data, 24'h123456);
            if (n == 2 * FT + 100) check_eq("solid_x100", w_data, 24'h123456);
        end

        // Abort at h=300 on line 5 of frame 3.
        r_en = 1'b0;
        step();
        check_eq("abort_zero", {w_de, w_hs, w_vs, w_fs, w_x, w_y, w_data}, 0);
        r_sel = 2'd1;
        repeat (3) step();
        check_eq("idle_zero", {w_de, w_hs, w_vs, w_fs, w_x, w_y, w_data}, 0);
        r_en = 1'b1;
        step();
        check_eq("restart_fs_xy", {w_fs, w_de, w_x, w_y}, {1'b1, 1'b1, 24'd0});
        tally(0, 2'd1);
        for (int n = 1; n <= 120; n++) begin
            step();
            tally(n, 2'd1);
            if (n == 100) check_eq("grey_x100", w_data, 24'h191919);
        end

        // Checkerboard, selected while idle.
        r_en  = 1'b0;
        r_sel = 2'd2;
        repeat (2) step();
        r_en = 1'b1;
        for (int n = 0; n < HT; n++) begin
            step();
            tally(n, 2'd2);
            if (n == 32) check_eq("chk_x32", w_data, 24'h000000);
            if (n == 64) check_eq("chk_x64", w_data, 24'hFFFFFF);
        end

        // Asynchronous reset mid-line.
        #2;
        r_rst = 1'b1;
        #1;
        check_eq("async_rst_zero", {w_de, w_hs, w_vs, w_fs, w_x, w_y, w_data}, 0);
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            step();
            tally(n, 2'd2);
            if (n == 0) check_eq("rst_restart_fs", w_fs, 1);
        end

        check_eq("frame_de",   r_e_de, 0);
        check_eq("frame_hs",   r_e_hs, 0);
        check_eq("frame_vs",   r_e_vs, 0);
        check_eq("frame_fs",   r_e_fs, 0);
        check_eq("frame_xy",   r_e_xy, 0);
        check_eq("frame_data", r_e_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
